// File: rtl/bcd_ascii_pkg.sv
// Shared types and constants for the BCD-to-ASCII byte serialiser.
// Holds the frame FSM encoding, the ASCII character codes and the hundreds-digit legalisation helper.
package bcd_ascii_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HUND = 3'd1,
        S_TENS = 3'd2,
        S_ONES = 3'd3,
        S_CR   = 3'd4,
        S_LF   = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ERR  = 8'h3F;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Hundreds is a 2-bit field; value 3 is illegal, so widen it to a nibble
    // that the shared digit encoder maps to the error character.
    function automatic logic [3:0] hund_digit(input logic [1:0] h);
        return (h == 2'd3) ? 4'hF : {2'b00, h};
    endfunction

endpackage

// File: rtl/digit_to_ascii.sv
// Purpose: maps one BCD digit to its ASCII character, non-decimal nibbles to '?'.
// Latency: purely combinational.
// Backpressure: none; the caller holds the digit stable while a byte is stalled.
module digit_to_ascii
    import bcd_ascii_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_ZERO + {4'b0000, digit};
        if (digit > 4'd9) begin
            ascii = ASCII_ERR;
        end
    end

endmodule

// File: rtl/bcd_ascii_tx.sv
// Purpose: serialises a captured 3-digit BCD value as ASCII (plus optional CR/LF) onto a valid/ready byte stream.
// Latency: first byte valid 1 cycle after start; done pulses 1 cycle after the last handshake.
// Backpressure: tx_ready low stalls the current byte with tx_data/tx_valid held; BCD_ASCII_BLANK_EN suppresses leading zeros.
module bcd_ascii_tx
    import bcd_ascii_pkg::*;
#(
    parameter bit SEND_CR = 1'b1,
    parameter bit SEND_LF = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] bcd_in,
    input  logic       start,
    output logic       busy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       done
);

    state_t     state;
    state_t     state_nxt;
    logic [9:0] bcd_q;
    logic       done_q;
    logic       hs;
    logic [3:0] digit_sel;
    logic [7:0] digit_ascii;

    assign hs = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= S_IDLE;
            bcd_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            if (state == S_IDLE && start) begin
                bcd_q <= bcd_in;
            end
            // Character states only fall back to IDLE on their final handshake.
            done_q <= (state != S_IDLE) && (state_nxt == S_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
`ifdef BCD_ASCII_BLANK_EN
                    if (bcd_in[9:8] != 2'd0) begin
                        state_nxt = S_HUND;
                    end else if (bcd_in[7:4] != 4'd0) begin
                        state_nxt = S_TENS;
                    end else begin
                        state_nxt = S_ONES;
                    end
`else
                    state_nxt = S_HUND;
`endif
                end
            end
            S_HUND: if (hs) state_nxt = S_TENS;
            S_TENS: if (hs) state_nxt = S_ONES;
            S_ONES: begin
                if (hs) begin
                    if (SEND_CR) begin
                        state_nxt = S_CR;
                    end else if (SEND_LF) begin
                        state_nxt = S_LF;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_CR: begin
                if (hs) begin
                    state_nxt = SEND_LF ? S_LF : S_IDLE;
                end
            end
            S_LF:    if (hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        digit_sel = bcd_q[3:0];
        unique case (state)
            S_HUND:  digit_sel = hund_digit(bcd_q[9:8]);
            S_TENS:  digit_sel = bcd_q[7:4];
            default: digit_sel = bcd_q[3:0];
        endcase
    end

    digit_to_ascii u_digit (
        .digit (digit_sel),
        .ascii (digit_ascii)
    );

    always_comb begin
        busy     = (state != S_IDLE);
        tx_valid = (state != S_IDLE);
        tx_data  = 8'h00;
        unique case (state)
            S_HUND, S_TENS, S_ONES: tx_data = digit_ascii;
            S_CR:                   tx_data = ASCII_CR;
            S_LF:                   tx_data = ASCII_LF;
            default:                tx_data = 8'h00;
        endcase
        done = done_q;
    end

endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Directed bench for bcd_ascii_tx: default instance plus a SEND_CR=0 instance; honours BCD_ASCII_BLANK_EN.
module tb_bcd_ascii_tx;

    logic       clk;
    logic       clr;
    logic [9:0] bcd_in, bcd_in2;
    logic       start, start2;
    logic       tx_ready;
    logic       busy, busy2;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       done, done2;

    logic       use2;
    logic       o_busy, o_valid, o_done;
    logic [7:0] o_data;

    int vectors = 0;
    int miscompares = 0;

    bcd_ascii_tx dut (
        .clk      (clk),
        .clr      (clr),
        .bcd_in   (bcd_in),
        .start    (start),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (done)
    );

    bcd_ascii_tx #(.SEND_CR(1'b0), .SEND_LF(1'b1)) dut2 (
        .clk      (clk),
        .clr      (clr),
        .bcd_in   (bcd_in2),
        .start    (start2),
        .busy     (busy2),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready),
        .done     (done2)
    );

    always_comb begin
        o_busy  = use2 ? busy2     : busy;
        o_valid = use2 ? tx_valid2 : tx_valid;
        o_done  = use2 ? done2     : done;
        o_data  = use2 ? tx_data2  : tx_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [9:0] v);
        if (use2) begin
            bcd_in2 = v;
            start2  = 1'b1;
        end else begin
            bcd_in = v;
            start  = 1'b1;
        end
        step();
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Checks n consecutive bytes (MSB byte of exp first) then the done cycle.
    // At byte index inject_at, a competing start with a different value is pulsed.
    task automatic expect_bytes(input string tag, input logic [39:0] exp, input int n, input int inject_at);
        for (int i = 0; i < n; i++) begin
            chk1($sformatf("%s valid%0d", tag, i), o_valid, 1'b1);
            chk1($sformatf("%s busy%0d", tag, i), o_busy, 1'b1);
            chk1($sformatf("%s nodone%0d", tag, i), o_done, 1'b0);
            chk8($sformatf("%s byte%0d", tag, i), o_data, exp[8*(n-1-i) +: 8]);
            if (i == inject_at) begin
                bcd_in = 10'h111;
                start  = 1'b1;
            end
            step();
            start = 1'b0;
        end
        chk1({tag, " done"}, o_done, 1'b1);
        chk1({tag, " busy_end"}, o_busy, 1'b0);
        chk1({tag, " valid_end"}, o_valid, 1'b0);
    endtask

    task automatic frame(input string tag, input logic [9:0] v, input logic [39:0] exp, input int n);
        start_frame(v);
        expect_bytes(tag, exp, n, -1);
    endtask

    initial begin
        clr      = 1'b1;
        bcd_in   = '0;
        bcd_in2  = '0;
        start    = 1'b0;
        start2   = 1'b0;
        tx_ready = 1'b1;
        use2     = 1'b0;
        step();
        step();
        chk1("rst busy", busy, 1'b0);
        chk1("rst valid", tx_valid, 1'b0);
        chk8("rst data", tx_data, 8'h00);
        chk1("rst done", done, 1'b0);
        chk1("rst busy2", busy2, 1'b0);
        chk1("rst valid2", tx_valid2, 1'b0);
        clr = 1'b0;
        step();
        chk1("idle valid", tx_valid, 1'b0);

        // 200 then an immediate back-to-back start in the done cycle
        frame("d200", 10'h200, 40'h32_30_30_0D_0A, 5);
`ifdef BCD_ASCII_BLANK_EN
        frame("d099", 10'h099, 40'h00_39_39_0D_0A, 4);
`else
        frame("d099", 10'h099, 40'h30_39_39_0D_0A, 5);
`endif
        step();
        chk1("d099 done_low", done, 1'b0);
        chk1("d099 idle", tx_valid, 1'b0);

        // Backpressure on the first byte
        start_frame(10'h128);
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk8($sformatf("bp hold_data%0d", k), tx_data, 8'h31);
            chk1($sformatf("bp hold_valid%0d", k), tx_valid, 1'b1);
            step();
        end
        tx_ready = 1'b1;
        expect_bytes("bp", 40'h31_32_38_0D_0A, 5, -1);
        step();

        // Illegal digits
`ifdef BCD_ASCII_BLANK_EN
        frame("d0fa", 10'h0FA, 40'h00_3F_3F_0D_0A, 4);
`else
        frame("d0fa", 10'h0FA, 40'h30_3F_3F_0D_0A, 5);
`endif
        step();
        frame("d300", 10'h300, 40'h3F_30_30_0D_0A, 5);
        step();

        // Start and bcd_in change while busy are ignored
        start_frame(10'h255);
        expect_bytes("d255", 40'h32_35_35_0D_0A, 5, 1);
        step();
        chk1("d255 no_restart", tx_valid, 1'b0);

        // clr mid-frame after the second byte is accepted
        start_frame(10'h255);
        chk8("clr b0", tx_data, 8'h32);
        step();
        chk8("clr b1", tx_data, 8'h35);
        step();
        chk8("clr b2", tx_data, 8'h35);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk1("clr valid", tx_valid, 1'b0);
        chk1("clr busy", busy, 1'b0);
        chk1("clr done", done, 1'b0);
        chk8("clr data", tx_data, 8'h00);
        step();
        chk1("clr done_after", done, 1'b0);

        // clr wins over start
        bcd_in = 10'h200;
        start  = 1'b1;
        clr    = 1'b1;
        step();
        start = 1'b0;
        clr   = 1'b0;
        chk1("clrstart valid", tx_valid, 1'b0);
        chk1("clrstart busy", busy, 1'b0);
        step();
        chk1("clrstart idle", tx_valid, 1'b0);

`ifdef BCD_ASCII_BLANK_EN
        frame("d045", 10'h045, 40'h00_34_35_0D_0A, 4);
`else
        frame("d045", 10'h045, 40'h30_34_35_0D_0A, 5);
`endif
        step();

        // SEND_CR=0 instance
        use2 = 1'b1;
        step();
`ifdef BCD_ASCII_BLANK_EN
        frame("n007", 10'h007, 40'h00_00_00_37_0A, 2);
        step();
        frame("n000", 10'h000, 40'h00_00_00_30_0A, 2);
        step();
        frame("n045", 10'h045, 40'h00_00_34_35_0A, 3);
`else
        frame("n007", 10'h007, 40'h00_30_30_37_0A, 4);
        step();
        frame("n000", 10'h000, 40'h00_30_30_30_0A, 4);
        step();
        frame("n045", 10'h045, 40'h00_30_34_35_0A, 4);
`endif
        step();
        chk1("n idle", tx_valid2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
